// File: rtl/traffic_light_monitor.sv
// Passive observer of the two-road light interface: decodes the lamp pair each clock,
// follows the P0..P3 phase sequence with per-phase dwell, and latches sticky fault flags.
module traffic_light_monitor #(
  parameter int unsigned T_GA  = 8,
  parameter int unsigned T_YA  = 3,
  parameter int unsigned T_GB  = 10,
  parameter int unsigned T_YB  = 3,
  parameter int unsigned CNT_W = 5,
  parameter int unsigned CYC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       lightA,
  input  logic [2:0]       lightB,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             phase_vld,
  output logic [3:0]       err_flags,
  output logic             fault,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  localparam logic [3:0] ERR_PATTERN = 4'b0001;
  localparam logic [3:0] ERR_ORDER   = 4'b0010;
  localparam logic [3:0] ERR_SHORT   = 4'b0100;
  localparam logic [3:0] ERR_LONG    = 4'b1000;

  // Returns {legal, phase}; anything outside the four phase pairs is illegal.
  function automatic logic [2:0] decode(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] res;
    res = 3'b000;
    case ({a, b})
      {LAMP_G, LAMP_R}: res = 3'b100;
      {LAMP_Y, LAMP_R}: res = 3'b101;
      {LAMP_R, LAMP_G}: res = 3'b110;
      {LAMP_R, LAMP_Y}: res = 3'b111;
      default:          res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [CNT_W-1:0] dwell_limit(input logic [1:0] p);
    logic [CNT_W-1:0] lim;
    lim = '0;
    case (p)
      2'd0:    lim = CNT_W'(T_GA);
      2'd1:    lim = CNT_W'(T_YA);
      2'd2:    lim = CNT_W'(T_GB);
      2'd3:    lim = CNT_W'(T_YB);
      default: lim = CNT_W'(T_GA);
    endcase
    return lim;
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       phase_r, phase_s;
  logic [CNT_W-1:0] dwell_r, dwell_s;
  logic             first_r, first_s;
  logic [3:0]       err_r, err_s;
  logic [CYC_W-1:0] cyc_r, cyc_s;
  logic             vld_r, vld_s;
  logic             fault_r, fault_s;
  logic [2:0]       dec_s;
  logic [1:0]       nxt_phase_s;
  logic [CNT_W-1:0] limit_s;

  // State and tracking registers; every output is taken straight from here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_SYNC;
      phase_r <= 2'd0;
      dwell_r <= '0;
      first_r <= 1'b0;
      err_r   <= 4'b0000;
      cyc_r   <= '0;
      vld_r   <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      dwell_r <= dwell_s;
      first_r <= first_s;
      err_r   <= err_s;
      cyc_r   <= cyc_s;
      vld_r   <= vld_s;
      fault_r <= fault_s;
    end
  end

  // Next-state: phase tracking, dwell checks and flag latching; clr overrides all.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    dwell_s     = dwell_r;
    first_s     = first_r;
    err_s       = err_r;
    cyc_s       = cyc_r;
    dec_s       = decode(lightA, lightB);
    nxt_phase_s = phase_r + 2'd1;
    // The first phase after lock gets one extra cycle for the controller's reset value.
    limit_s     = dwell_limit(phase_r) + {{(CNT_W-1){1'b0}}, first_r};
    if (clr) begin
      state_s = ST_SYNC;
      err_s   = 4'b0000;
      cyc_s   = '0;
      dwell_s = '0;
    end else begin
      case (state_r)
        ST_SYNC: begin
          if (dec_s[2]) begin
            state_s = ST_RUN;
            phase_s = dec_s[1:0];
            dwell_s = {{(CNT_W-1){1'b0}}, 1'b1};
            first_s = 1'b1;
          end else begin
            state_s = ST_SYNC;
          end
        end
        ST_RUN: begin
          if (!dec_s[2]) begin
            err_s   = err_r | ERR_PATTERN;
            state_s = ST_FAULT;
          end else if (dec_s[1:0] == phase_r) begin
            if (dwell_r == limit_s) begin
              err_s   = err_r | ERR_LONG;
              state_s = ST_FAULT;
            end else begin
              dwell_s = dwell_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else if (dec_s[1:0] == nxt_phase_s) begin
            if (!first_r && (dwell_r != dwell_limit(phase_r))) begin
              err_s   = err_r | ERR_SHORT;
              state_s = ST_FAULT;
            end else begin
              phase_s = nxt_phase_s;
              dwell_s = {{(CNT_W-1){1'b0}}, 1'b1};
              first_s = 1'b0;
              if (phase_r == 2'd3) begin
                cyc_s = cyc_r + {{(CYC_W-1){1'b0}}, 1'b1};
              end else begin
                cyc_s = cyc_r;
              end
            end
          end else begin
            err_s   = err_r | ERR_ORDER;
            state_s = ST_FAULT;
          end
        end
        ST_FAULT: state_s = ST_FAULT;
        default:  state_s = ST_SYNC;
      endcase
    end
  end

  // Output decode from the next state so the flags register alongside it.
  always_comb begin
    vld_s   = 1'b0;
    fault_s = 1'b0;
    case (state_s)
      ST_RUN:   vld_s   = 1'b1;
      ST_FAULT: fault_s = 1'b1;
      default: begin
        vld_s   = 1'b0;
        fault_s = 1'b0;
      end
    endcase
  end

  assign phase     = phase_r;
  assign phase_vld = vld_r;
  assign err_flags = err_r;
  assign fault     = fault_r;
  assign cycle_cnt = cyc_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: directed scenarios plus randomized
// phase streams, all compared against a rule-level reference model.
module tb_traffic_light_monitor;

  logic        clk;
  logic        rstn;
  logic [2:0]  lightA;
  logic [2:0]  lightB;
  logic        clr;
  logic [1:0]  phase;
  logic        phase_vld;
  logic [3:0]  err_flags;
  logic        fault;
  logic [15:0] cycle_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  traffic_light_monitor dut (
    .clk(clk), .rstn(rstn), .lightA(lightA), .lightB(lightB), .clr(clr),
    .phase(phase), .phase_vld(phase_vld), .err_flags(err_flags), .fault(fault),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lamp pairs and nominal lengths of P0..P3.
  logic [2:0] pat_a [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] pat_b [4] = '{3'b100, 3'b100, 3'b001, 3'b010};
  int         dur   [4] = '{8, 3, 10, 3};

  // Model mode: 0 = waiting for lock, 1 = tracking, 2 = faulted.
  int         m_mode, m_phase, m_dwell, m_cyc;
  bit         m_first;
  logic [3:0] m_flags;

  logic [23:0] dut_vec;
  assign dut_vec = {phase, phase_vld, err_flags, fault, cycle_cnt};

  function automatic logic [23:0] model_vec();
    return {2'(m_phase), (m_mode == 1), m_flags, (m_mode == 2), 16'(m_cyc)};
  endfunction

  function automatic int which_phase(input logic [2:0] a, input logic [2:0] b);
    for (int i = 0; i < 4; i++) if (a == pat_a[i] && b == pat_b[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_dwell = 0; m_cyc = 0; m_first = 0; m_flags = 4'b0000;
  endtask

  task automatic model_update(input logic [2:0] a, input logic [2:0] b, input logic c);
    int p;
    p = which_phase(a, b);
    if (c) begin
      m_mode = 0; m_flags = 4'b0000; m_cyc = 0; m_dwell = 0;
    end else if (m_mode == 0) begin
      if (p >= 0) begin m_mode = 1; m_phase = p; m_dwell = 1; m_first = 1; end
    end else if (m_mode == 1) begin
      if (p < 0) begin
        m_flags[0] = 1'b1; m_mode = 2;
      end else if (p == m_phase) begin
        if (m_dwell >= dur[m_phase] + (m_first ? 1 : 0)) begin m_flags[3] = 1'b1; m_mode = 2; end
        else m_dwell++;
      end else if (p == (m_phase + 1) % 4) begin
        if (!m_first && m_dwell != dur[m_phase]) begin m_flags[2] = 1'b1; m_mode = 2; end
        else begin
          if (m_phase == 3) m_cyc = (m_cyc + 1) % 65536;
          m_phase = p; m_dwell = 1; m_first = 0;
        end
      end else begin
        m_flags[1] = 1'b1; m_mode = 2;
      end
    end
  endtask

  // One sampled clock: drive, let the edge happen, advance the model, settle.
  task automatic step(input logic [2:0] a, input logic [2:0] b, input logic c);
    lightA = a; lightB = b; clr = c;
    @(posedge clk);
    model_update(a, b, c);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; clr = 1'b0; lightA = 3'b000; lightB = 3'b000;
    model_reset();
    #22;
    tests_run++;
    if (dut_vec !== 24'h0) begin
      tests_failed++; $display("FAIL reset: got %h, want 000000", dut_vec);
    end
    rstn = 1'b1;
  endtask

  task automatic test_golden();
    int sp [13] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};
    int sn [13] = '{9, 3, 10, 3, 8, 3, 10, 3, 8, 3, 10, 3, 1};
    for (int s = 0; s < 13; s++) begin
      for (int k = 0; k < sn[s]; k++) begin
        step(pat_a[sp[s]], pat_b[sp[s]], 1'b0);
        tests_run++;
        if (dut_vec !== model_vec() || phase !== 2'(sp[s]) || phase_vld !== 1'b1) begin
          tests_failed++;
          $display("FAIL golden s%0d k%0d: got %h, want %h (phase %0d)", s, k, dut_vec, model_vec(), sp[s]);
        end
      end
    end
    tests_run++;
    if (cycle_cnt !== 16'd3 || err_flags !== 4'b0000 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL golden_end: cyc %0d err %b fault %b, want 3 0000 0", cycle_cnt, err_flags, fault);
    end
  endtask

  task automatic test_short();
    int sp [7] = '{0, 1, 2, 3, 0, 1, 2};
    int sn [7] = '{8, 3, 10, 3, 8, 2, 1};
    step(3'b000, 3'b000, 1'b1);
    for (int s = 0; s < 7; s++)
      for (int k = 0; k < sn[s]; k++) step(pat_a[sp[s]], pat_b[sp[s]], 1'b0);
    tests_run++;
    if (err_flags !== 4'b0100 || fault !== 1'b1 || phase_vld !== 1'b0 || phase !== 2'd1) begin
      tests_failed++;
      $display("FAIL short: err %b fault %b vld %b ph %0d, want 0100 1 0 1", err_flags, fault, phase_vld, phase);
    end
    for (int k = 0; k < 4; k++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
      tests_run++;
      if (dut_vec !== model_vec() || err_flags !== 4'b0100) begin
        tests_failed++; $display("FAIL frozen k%0d: got %h, want %h", k, dut_vec, model_vec());
      end
    end
    step(pat_a[2], pat_b[2], 1'b1);
    tests_run++;
    if (err_flags !== 4'b0000 || fault !== 1'b0 || phase_vld !== 1'b0 || cycle_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL short_clr: err %b fault %b vld %b cyc %0d, want 0000 0 0 0", err_flags, fault, phase_vld, cycle_cnt);
    end
  endtask

  task automatic test_long();
    step(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) step(pat_a[1], pat_b[1], 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step(pat_a[2], pat_b[2], 1'b0);
      tests_run++;
      if (dut_vec !== model_vec() || err_flags !== ((k == 11) ? 4'b1000 : 4'b0000) || phase !== 2'd2) begin
        tests_failed++; $display("FAIL long k%0d: got %h, want %h", k, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_pattern();
    step(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(3'b001, 3'b001, 1'b0);
      tests_run++;
      if (err_flags !== 4'b0000 || phase_vld !== 1'b0 || fault !== 1'b0) begin
        tests_failed++; $display("FAIL sync_illegal k%0d: err %b vld %b, want 0000 0", k, err_flags, phase_vld);
      end
    end
    for (int k = 0; k < 3; k++) step(pat_a[0], pat_b[0], 1'b0);
    step(3'b001, 3'b001, 1'b0);
    tests_run++;
    if (err_flags !== 4'b0001 || fault !== 1'b1 || dut_vec !== model_vec()) begin
      tests_failed++; $display("FAIL pattern: err %b fault %b, want 0001 1", err_flags, fault);
    end
  endtask

  task automatic test_order_clr();
    step(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) step(pat_a[3], pat_b[3], 1'b0);
    for (int k = 0; k < 8; k++) step(pat_a[0], pat_b[0], 1'b0);
    step(pat_a[2], pat_b[2], 1'b0);
    tests_run++;
    if (err_flags !== 4'b0010 || fault !== 1'b1 || cycle_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL order: err %b fault %b cyc %0d, want 0010 1 1", err_flags, fault, cycle_cnt);
    end
    step(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 2; k++) step(pat_a[0], pat_b[0], 1'b0);
    step(pat_a[2], pat_b[2], 1'b1);
    tests_run++;
    if (err_flags !== 4'b0000 || fault !== 1'b0 || phase_vld !== 1'b0) begin
      tests_failed++; $display("FAIL clr_wins: err %b fault %b vld %b, want 0000 0 0", err_flags, fault, phase_vld);
    end
  endtask

  task automatic test_async_reset();
    step(3'b000, 3'b000, 1'b1);
    for (int k = 0; k < 3; k++) step(pat_a[1], pat_b[1], 1'b0);
    for (int k = 0; k < 4; k++) step(pat_a[2], pat_b[2], 1'b0);
    #3 rstn = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (dut_vec !== 24'h0) begin
      tests_failed++; $display("FAIL async_rst: got %h, want 000000", dut_vec);
    end
    @(posedge clk);
    #4 rstn = 1'b1;
    for (int k = 0; k < 3; k++) step(pat_a[3], pat_b[3], 1'b0);
    for (int k = 0; k < 8; k++) step(pat_a[0], pat_b[0], 1'b0);
    tests_run++;
    if (cycle_cnt !== 16'd1 || err_flags !== 4'b0000 || phase !== 2'd0 || dut_vec !== model_vec()) begin
      tests_failed++;
      $display("FAIL resume: cyc %0d err %b ph %0d, want 1 0000 0", cycle_cnt, err_flags, phase);
    end
  endtask

  task automatic test_random();
    int ph, n;
    step(3'b000, 3'b000, 1'b1);
    ph = $urandom_range(0, 3);
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 11) == 0 || (m_mode == 2 && $urandom_range(0, 2) == 0)) begin
        step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
      end else if ($urandom_range(0, 11) == 0) begin
        step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
      end else begin
        if ($urandom_range(0, 9) == 0) ph = $urandom_range(0, 3);
        n = dur[ph] + $urandom_range(0, 4) - 2;
        if ($urandom_range(0, 1) == 0) n = dur[ph];
        if (n < 1) n = 1;
        for (int k = 0; k < n; k++) begin
          step(pat_a[ph], pat_b[ph], 1'b0);
          tests_run++;
          if (dut_vec !== model_vec()) begin
            tests_failed++; $display("FAIL rand seg%0d k%0d: got %h, want %h", seg, k, dut_vec, model_vec());
          end
        end
        ph = (ph + 1) % 4;
        continue;
      end
      tests_run++;
      if (dut_vec !== model_vec()) begin
        tests_failed++; $display("FAIL rand seg%0d: got %h, want %h", seg, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_short();
    test_long();
    test_pattern();
    test_order_clr();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
